multicycle_control: RTL and testbench

Main control FSM for the multi-cycle RISC-V subset core (ld, sd, beq, R-type). It sequences fetch, decode, address/ALU execute, memory access and writeback over the shared ALU, memory port, immediate generator output and register file. It drives every datapath mux and enable each cycle. It waits on a ready handshake from the single shared instruction/data memory port, with a bounded wait.

---
 rtl/riscv_ctrl_pkg.sv | 50 +++++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V subset control path.
package riscv_ctrl_pkg;

    // Supported major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Control FSM states; encodings are visible on the debug port
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StLoadWb   = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StHalt     = 4'd9
    } state_t;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Sticky fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // True for opcodes that go through address calculation
    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unanswered memory-request cycles and flags a timeout.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,       // FSM is in a state that waits on memory
    input  logic ready,    // memory answered this cycle
    input  logic clear,    // FSM is leaving its current state
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LastCnt = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Timeout fires on the cycle the count would reach MAX_WAIT; ready wins
    always_comb begin
        timeout = en && !ready && (cnt_q == LastCnt);
        if (!en || ready || clear) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RISC-V subset core (ld, sd, beq, R-type).
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       memRead,
    output logic       memWrite,
    output logic       iOrD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       pcSource,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       regWrite,
    output logic       memToReg,
    output logic       instrDone,
    output logic [1:0] fault,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [6:0] op_reg_q, op_reg_d;
    logic [1:0] fault_q, fault_d;
    logic       wait_en;
    logic       timeout;

    assign wait_en = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .en      (wait_en),
        .ready   (memReady),
        .clear   (state_d != state_q),
        .timeout (timeout)
    );

    // Next-state and Moore output decode (pcWrite/irWrite also input-gated)
    always_comb begin
        state_d   = state_q;
        op_reg_d  = op_reg_q;
        fault_d   = fault_q;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iOrD      = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        pcSource  = 1'b0;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_REG;
        aluOp     = ALUOP_ADD;
        regWrite  = 1'b0;
        memToReg  = 1'b0;
        instrDone = 1'b0;

        unique case (state_q)
            StFetch: begin
                memRead = 1'b1;
                aluSrcA = SRCA_PC;
                aluSrcB = SRCB_FOUR;
                aluOp   = ALUOP_ADD;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StHalt;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            StDecode: begin
                op_reg_d = opcode;
                // Branch target computed here and parked in ALU-out
                aluSrcA  = SRCA_OLDPC;
                aluSrcB  = SRCB_IMM_SH1;
                aluOp    = ALUOP_ADD;
                if (is_mem_op(opcode)) begin
                    state_d = StMemAddr;
                end else if (opcode == OPC_RTYPE) begin
                    state_d = StRExec;
                end else if (opcode == OPC_BRANCH) begin
                    state_d = StBranch;
                end else begin
                    state_d = StHalt;
                    fault_d = FAULT_ILLEGAL;
                end
            end
            StMemAddr: begin
                aluSrcA = SRCA_REG;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_ADD;
                state_d = (op_reg_q == OPC_LOAD) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                memRead = 1'b1;
                iOrD    = 1'b1;
                if (memReady) begin
                    state_d = StLoadWb;
                end else if (timeout) begin
                    state_d = StHalt;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            StLoadWb: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                memWrite = 1'b1;
                iOrD     = 1'b1;
                if (memReady) begin
                    instrDone = 1'b1;
                    state_d   = StFetch;
                end else if (timeout) begin
                    state_d = StHalt;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            StRExec: begin
                aluSrcA = SRCA_REG;
                aluSrcB = SRCB_REG;
                aluOp   = ALUOP_FUNCT;
                state_d = StRWb;
            end
            StRWb: begin
                regWrite  = 1'b1;
                memToReg  = 1'b0;
                instrDone = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                aluSrcA   = SRCA_REG;
                aluSrcB   = SRCB_REG;
                aluOp     = ALUOP_SUB;
                pcSource  = 1'b1;
                pcWrite   = zero;
                instrDone = 1'b1;
                state_d   = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    // State, latched opcode and sticky fault registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            op_reg_q <= '0;
            fault_q  <= FAULT_NONE;
        end else begin
            state_q  <= state_d;
            op_reg_q <= op_reg_d;
            fault_q  <= fault_d;
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MAX_WAIT = 4).
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       memReady;
    logic       memRead, memWrite, iOrD, irWrite, pcWrite, pcSource;
    logic [1:0] aluSrcA, aluSrcB, aluOp;
    logic       regWrite, memToReg, instrDone;
    logic [1:0] fault;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .MAX_WAIT (4),
        .WAIT_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .memReady  (memReady),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .iOrD      (iOrD),
        .irWrite   (irWrite),
        .pcWrite   (pcWrite),
        .pcSource  (pcSource),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .aluOp     (aluOp),
        .regWrite  (regWrite),
        .memToReg  (memToReg),
        .instrDone (instrDone),
        .fault     (fault),
        .state     (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count retire pulses mid-cycle, then advance one clock
    task automatic tick();
        @(negedge clk);
        if (instrDone === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 7'b0;
        zero     = 1'b0;
        memReady = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_state", state, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_done", instrDone, 0);
        check_eq("rst_memread", memRead, 1);
        check_eq("rst_srcb", aluSrcB, 2'b01);

        // ld, memReady always high: 0,1,2,3,4,0
        opcode   = 7'b0000011;
        done_cnt = 0;
        check_eq("ld_c1_irw", {irWrite, pcWrite, pcSource}, 3'b110);
        tick();
        check_eq("ld_c2_state", state, 1);
        check_eq("ld_c2_alu", {aluSrcA, aluSrcB, aluOp}, 6'b10_11_00);
        tick();
        check_eq("ld_c3_state", state, 2);
        check_eq("ld_c3_alu", {aluSrcA, aluSrcB, aluOp}, 6'b01_10_00);
        tick();
        check_eq("ld_c4_state", state, 3);
        check_eq("ld_c4_mem", {memRead, iOrD, regWrite}, 3'b110);
        tick();
        check_eq("ld_c5_state", state, 4);
        check_eq("ld_c5_wb", {regWrite, memToReg, instrDone}, 3'b111);
        tick();
        check_eq("ld_back_fetch", state, 0);
        check_eq("ld_done_cnt", done_cnt, 1);

        // beq taken then not taken, 3 cycles each
        opcode = 7'b1100011;
        zero   = 1'b1;
        tick();
        tick();
        check_eq("beq1_state", state, 8);
        check_eq("beq1_pc", {pcWrite, pcSource, instrDone}, 3'b111);
        check_eq("beq1_alu", {aluSrcA, aluSrcB, aluOp}, 6'b01_00_01);
        tick();
        check_eq("beq1_fetch", state, 0);
        zero = 1'b0;
        tick();
        tick();
        check_eq("beq0_state", state, 8);
        check_eq("beq0_pc", {pcWrite, pcSource, instrDone}, 3'b011);
        tick();
        check_eq("beq0_fetch", state, 0);

        // sd with memReady late by 3 cycles in MEM_WRITE
        opcode   = 7'b0100011;
        done_cnt = 0;
        tick();
        tick();
        tick();
        memReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("sd_wait%0d", i), {state, memWrite, iOrD, instrDone},
                     {4'd5, 3'b110});
            tick();
        end
        memReady = 1'b1;
        #1;
        check_eq("sd_ready", {state, memWrite, iOrD, instrDone}, {4'd5, 3'b111});
        tick();
        check_eq("sd_fetch", state, 0);
        check_eq("sd_done_cnt", done_cnt, 1);

        // Illegal opcode halts with fault 01 until reset
        opcode = 7'b1111111;
        tick();
        tick();
        check_eq("ill_state", state, 9);
        check_eq("ill_fault", fault, 2'b01);
        check_eq("ill_outs", {memRead, irWrite, pcWrite, regWrite, instrDone, aluSrcB}, 0);
        for (int i = 0; i < 20; i++) begin
            memReady = i[0];
            tick();
        end
        check_eq("ill_hold_state", state, 9);
        check_eq("ill_hold_fault", fault, 2'b01);
        memReady = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("ill_rst_state", state, 0);
        check_eq("ill_rst_fault", fault, 0);

        // Fetch timeout after 4 unanswered cycles
        memReady = 1'b0;
        tick();
        tick();
        tick();
        check_eq("to_still_fetch", state, 0);
        tick();
        check_eq("to_state", state, 9);
        check_eq("to_fault", fault, 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // memReady in the 4th wait cycle wins; then an R-type completes
        opcode = 7'b0110011;
        tick();
        tick();
        tick();
        memReady = 1'b1;
        #1;
        check_eq("race_irw", irWrite, 1);
        tick();
        check_eq("race_state", state, 1);
        check_eq("race_fault", fault, 0);
        tick();
        check_eq("r_exec", {state, aluSrcA, aluSrcB, aluOp}, {4'd6, 6'b01_00_10});
        tick();
        check_eq("r_wb", {state, regWrite, memToReg, instrDone}, {4'd7, 3'b101});
        tick();
        check_eq("r_fetch", state, 0);

        // Reset during MEM_READ abandons the load
        opcode = 7'b0000011;
        tick();
        tick();
        tick();
        memReady = 1'b0;
        done_cnt = 0;
        #1;
        check_eq("rmr_state", state, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rmr_after", {state, regWrite, instrDone}, 6'd0);
        check_eq("rmr_done_cnt", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
